// File: rtl/rv32i_types.sv
// Shared RV32I types used by the MEM-stage data-memory access unit.
package rv32i_types;

    localparam int unsigned BE_W  = 4;
    localparam int unsigned OFF_W = 2;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [SEL_W-1:0] {
        mdr_lw  = 3'b000,
        mdr_lh  = 3'b001,
        mdr_lhu = 3'b010,
        mdr_lb  = 3'b011,
        mdr_lbu = 3'b100
    } mdr_sel_t;

    typedef enum logic [1:0] {
        DM_IDLE   = 2'd0,
        DM_ACCESS = 2'd1,
        DM_DONE   = 2'd2
    } dmem_state_t;

    // Access size comes from the byte enable for stores and from mdr_sel for loads.
    function automatic logic is_misaligned(input logic            is_write,
                                           input logic [BE_W-1:0] be,
                                           input logic [SEL_W-1:0] sel,
                                           input logic [OFF_W-1:0] off);
        logic half;
        logic word;
        if (is_write) begin
            half = (be == 4'b0011);
            word = (be == 4'b1111);
        end else begin
            half = (sel == mdr_lh) || (sel == mdr_lhu);
            word = !(half || (sel == mdr_lb) || (sel == mdr_lbu));
        end
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns the memory read word to the access offset and sign/zero-extends it.
module load_extend
    import rv32i_types::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  offset,
    input  logic [SEL_W-1:0]  mdr_sel,
    output logic [DATA_W-1:0] load_data
);

    logic [DATA_W-1:0] word;

    always_comb begin
        word = rdata >> {offset, 3'b000};
        unique case (mdr_sel)
            mdr_lb:  load_data = {{(DATA_W-8){word[7]}}, word[7:0]};
            mdr_lbu: load_data = {{(DATA_W-8){1'b0}}, word[7:0]};
            mdr_lh:  load_data = {{(DATA_W-16){word[15]}}, word[15:0]};
            mdr_lhu: load_data = {{(DATA_W-16){1'b0}}, word[15:0]};
            default: load_data = word;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access FSM: request/response handshake, store lane shift, load extend.
// Optional DMEM_MISALIGN_CHECK_EN: misaligned halfword/word requests fault straight to DONE.
module dmem_access_unit
    import rv32i_types::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [BE_W-1:0]   mem_byte_enable,
    input  logic [SEL_W-1:0]  mdr_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pipe_advance,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [BE_W-1:0]   dmem_byte_enable,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              misaligned
);

    dmem_state_t         state_q, state_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-3:0]   addr_q, addr_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   load_q, load_d;
    logic                mis_q, mis_d;
    logic                memop_c;
    logic                mis_req_c;
    logic [DATA_W-1:0]   ext_data_c;

    assign memop_c = req_valid & (mem_read | mem_write);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign mis_req_c = is_misaligned(mem_write, mem_byte_enable, mdr_sel, addr[1:0]);
`else
    assign mis_req_c = 1'b0;
`endif

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .rdata     (dmem_rdata),
        .offset    (off_q),
        .mdr_sel   (sel_q),
        .load_data (ext_data_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DM_IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            off_q   <= '0;
            sel_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            sel_q   <= sel_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        off_d   = off_q;
        sel_d   = sel_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        mis_d   = mis_q;
        unique case (state_q)
            DM_IDLE: begin
                if (memop_c) begin
                    off_d  = addr[1:0];
                    sel_d  = mdr_sel;
                    addr_d = addr[ADDR_W-1:2];
                    if (mis_req_c) begin
                        state_d = DM_DONE;
                        mis_d   = 1'b1;
                        load_d  = '0;
                    end else begin
                        // Write wins when both read and write are requested.
                        state_d = DM_ACCESS;
                        rd_d    = mem_read & ~mem_write;
                        wr_d    = mem_write;
                        be_d    = BE_W'(mem_byte_enable << addr[1:0]);
                        wdata_d = DATA_W'(wdata << {addr[1:0], 3'b000});
                    end
                end
            end
            DM_ACCESS: begin
                if (dmem_resp) begin
                    state_d = DM_DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    be_d    = '0;
                    wdata_d = '0;
                    load_d  = wr_q ? '0 : ext_data_c;
                end
            end
            DM_DONE: begin
                if (pipe_advance) begin
                    state_d = DM_IDLE;
                    mis_d   = 1'b0;
                end
            end
            default: state_d = DM_IDLE;
        endcase
    end

    // The captured address is only authoritative while the access is outstanding.
    assign dmem_address     = (state_q == DM_ACCESS) ? {addr_q, 2'b00}
                                                     : {addr[ADDR_W-1:2], 2'b00};
    assign dmem_read        = rd_q;
    assign dmem_write       = wr_q;
    assign dmem_byte_enable = be_q;
    assign dmem_wdata       = wdata_q;
    assign load_data        = load_q;
    assign misaligned       = mis_q;
    assign stall            = rst_n & memop_c & (state_q != DM_DONE);

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed test-plan cases plus random accesses vs a byte-level model.
module tb_dmem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [2:0]  mdr_sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pipe_advance;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    dmem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_byte_enable  (mem_byte_enable),
        .mdr_sel          (mdr_sel),
        .addr             (addr),
        .wdata            (wdata),
        .pipe_advance     (pipe_advance),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .load_data        (load_data),
        .stall            (stall),
        .misaligned       (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load result: bytes starting at the offset, missing bytes read as zero, then extended.
    function automatic logic [31:0] m_load(input logic [31:0] rdata, input int off, input int sel);
        int          n;
        longint      v;
        logic [7:0]  b;
        n = (sel == 1 || sel == 2) ? 2 : ((sel == 3 || sel == 4) ? 1 : 4);
        v = 0;
        for (int i = 0; i < n; i++) begin
            b = (off + i < 4) ? rdata[8*(off+i) +: 8] : 8'h00;
            v = v + (longint'(b) << (8 * i));
        end
        if ((sel == 1 || sel == 3) && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] be, input int off);
        int v;
        v = (int'(be) << off) & 15;
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int off);
        return 32'(longint'(wd) << (8 * off));
    endfunction

    function automatic logic m_mis(input logic wr, input logic [3:0] be, input int sel, input int off);
        int size;
        if (wr) size = (be == 4'b0011) ? 2 : ((be == 4'b1111) ? 4 : 1);
        else    size = (sel == 1 || sel == 2) ? 2 : ((sel == 3 || sel == 4) ? 1 : 4);
        return (size > 1) && ((off % size) != 0);
    endfunction

    // One complete access: IDLE launch, nwait+1 ACCESS cycles, nadv+1 DONE cycles, back to IDLE.
    task automatic run_op(input logic rd, input logic wr, input logic [3:0] be, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                          input int nwait, input int nadv);
        int          off;
        logic        emis;
        logic        erd;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] eld;
        off  = int'(a[1:0]);
        erd  = rd && !wr;
        ebe  = m_be(be, off);
        ewd  = m_wdata(wd, off);
        eld  = wr ? 32'h0 : m_load(rdat, off, int'(sel));
`ifdef DMEM_MISALIGN_CHECK_EN
        emis = m_mis(wr, be, int'(sel), off);
`else
        emis = 1'b0;
`endif
        step();
        req_valid = 1'b1; mem_read = rd; mem_write = wr; mem_byte_enable = be;
        mdr_sel = sel; addr = a; wdata = wd; pipe_advance = 1'b0; dmem_resp = 1'b0;
        dmem_rdata = $urandom;
        #1;
        chk("launch_stall", 32'(stall), 32'd1);
        chk("launch_rd", 32'(dmem_read), 32'd0);
        chk("launch_wr", 32'(dmem_write), 32'd0);
        chk("launch_addr", dmem_address, {a[31:2], 2'b00});
        if (emis) begin
            step();
            addr = $urandom;
            #1;
            chk("mis_flag", 32'(misaligned), 32'd1);
            chk("mis_stall", 32'(stall), 32'd0);
            chk("mis_rd", 32'(dmem_read), 32'd0);
            chk("mis_wr", 32'(dmem_write), 32'd0);
            chk("mis_load", load_data, 32'h0);
            pipe_advance = 1'b1;
            step();
            req_valid = 1'b0; pipe_advance = 1'b0;
            #1;
            chk("mis_clear", 32'(misaligned), 32'd0);
        end else begin
            for (int i = 0; i <= nwait; i++) begin
                step();
                addr = $urandom; wdata = $urandom;
                dmem_resp  = (i == nwait);
                dmem_rdata = (i == nwait) ? rdat : $urandom;
                #1;
                chk("acc_stall", 32'(stall), 32'd1);
                chk("acc_rd", 32'(dmem_read), 32'(erd));
                chk("acc_wr", 32'(dmem_write), 32'(wr));
                chk("acc_addr", dmem_address, {a[31:2], 2'b00});
                chk("acc_be", 32'(dmem_byte_enable), 32'(ebe));
                chk("acc_wdata", dmem_wdata, ewd);
                chk("acc_mis", 32'(misaligned), 32'd0);
            end
            for (int d = 0; d <= nadv; d++) begin
                step();
                dmem_resp    = (d == 0);
                dmem_rdata   = $urandom;
                pipe_advance = (d == nadv);
                #1;
                chk("done_stall", 32'(stall), 32'd0);
                chk("done_rd", 32'(dmem_read), 32'd0);
                chk("done_wr", 32'(dmem_write), 32'd0);
                chk("done_load", load_data, eld);
                chk("done_mis", 32'(misaligned), 32'd0);
            end
            step();
            req_valid = 1'b0; pipe_advance = 1'b0; dmem_resp = 1'b0;
            #1;
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_rd", 32'(dmem_read), 32'd0);
            chk("idle_wr", 32'(dmem_write), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rbe;
        int          rw;
        int          bsel;

        rst_n = 1'b0; req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        mem_byte_enable = 4'hF; mdr_sel = 3'b000; addr = 32'h1234_5677; wdata = 32'h0;
        pipe_advance = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'h0;

        step();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rd", 32'(dmem_read), 32'd0);
        chk("rst_wr", 32'(dmem_write), 32'd0);
        chk("rst_load", load_data, 32'h0);
        chk("rst_mis", 32'(misaligned), 32'd0);
        chk("rst_be", 32'(dmem_byte_enable), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_addr", dmem_address, 32'h1234_5674);
        rst_n = 1'b1; req_valid = 1'b0;

        // Directed cases from the test plan.
        run_op(1'b1, 1'b0, 4'b0001, 3'b011, 32'h0000_1003, 32'h0, 32'h80FF_1234, 2, 0);
        run_op(1'b1, 1'b0, 4'b0011, 3'b010, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0, 0);
        run_op(1'b0, 1'b1, 4'b0011, 3'b000, 32'h0000_3002, 32'h0000_ABCD, 32'hFFFF_FFFF, 2, 1);
        run_op(1'b1, 1'b0, 4'b1111, 3'b000, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 1, 3);
        run_op(1'b1, 1'b0, 4'b1111, 3'b000, 32'h0000_4001, 32'h0, 32'h1122_3344, 0, 0);
        run_op(1'b1, 1'b1, 4'b1111, 3'b000, 32'h0000_6000, 32'hDEAD_BEEF, 32'h5555_5555, 1, 0);

        // Reset while an access is outstanding; a late response must be ignored.
        step();
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mdr_sel = 3'b000;
        mem_byte_enable = 4'hF; addr = 32'h0000_7000;
        step();
        chk("pre_rst_rd", 32'(dmem_read), 32'd1);
        rst_n = 1'b0;
        step();
        addr = 32'h0000_8007;
        #1;
        chk("mid_rst_rd", 32'(dmem_read), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_addr", dmem_address, 32'h0000_8004);
        rst_n = 1'b1; req_valid = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        step();
        dmem_resp = 1'b0;
        #1;
        chk("late_resp_load", load_data, 32'h0);
        chk("late_resp_rd", 32'(dmem_read), 32'd0);
        run_op(1'b1, 1'b0, 4'b1111, 3'b100, 32'h0000_9001, 32'h0, 32'h0000_9A00, 1, 0);

        // Random accesses, half of them forced word-aligned.
        for (int n = 0; n < 40; n++) begin
            rw   = $urandom_range(1, 3);
            bsel = $urandom_range(0, 2);
            rbe  = (bsel == 0) ? 4'b0001 : ((bsel == 1) ? 4'b0011 : 4'b1111);
            ra   = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            run_op(rw[0], rw[1], rbe, 3'($urandom_range(0, 7)), ra, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
